// File: rtl/lsu_addr_gen_pkg.sv
// Shared load/store encodings and the address-generator state type.
package lsu_addr_gen_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } cs_size;

    typedef enum logic {
        EXT_Z = 1'b0,
        EXT_S = 1'b1
    } cs_ext;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_LO = 3'd1,
        ADDR_HI = 3'd2,
        ISSUE   = 3'd3,
        WAIT    = 3'd4,
        DRAIN   = 3'd5
    } agu_state_e;

endpackage

// File: rtl/lsu_addr_gen.sv
// Effective-address generator feeding the LSU: rs1 + sext(imm) over two 16-bit halves, start >= 3 cycles after accept.
// Backpressure: req_ready only in IDLE; the start is held back in ISSUE until lsu_ready is high.
module lsu_addr_gen
    import lsu_addr_gen_pkg::*;
#(
    parameter int IMM_W        = 12,
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    output logic             req_ready_o,
    input  logic             dir_i,
    input  cs_size           size_i,
    input  cs_ext            ext_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic             rf_hi_o,
    input  logic [15:0]      rs1_half_i,
    input  logic [15:0]      rs2_half_i,
    output logic             lsu_start_o,
    output logic             lsu_dir_o,
    output cs_size           lsu_size_o,
    output cs_ext            lsu_ext_o,
    output logic [31:0]      lsu_addr_o,
    output logic [31:0]      lsu_wdata_o,
    input  logic             lsu_ready_i,
    input  logic             lsu_valid_i,
    input  logic             lsu_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             misalign_o,
    output logic             err_o
);

    agu_state_e       state, state_d;
    logic [IMM_W-1:0] imm_q;
    logic             carry_q;
    logic [31:0]      imm_sext;
    logic [16:0]      sum_lo;
    logic [15:0]      sum_hi;
    logic             misaligned;
    logic             trap;

    assign imm_sext = {{(32-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    assign sum_lo   = {1'b0, rs1_half_i} + {1'b0, imm_sext[15:0]};
    // Top-half carry-out is dropped: addresses wrap mod 2^32.
    assign sum_hi   = rs1_half_i + imm_sext[31:16] + {15'd0, carry_q};

    // Low address bits are already registered by the time ADDR_HI evaluates this.
    always_comb begin
        misaligned = 1'b0;
        case (lsu_size_o)
            SIZE_W:  misaligned = |lsu_addr_o[1:0];
            SIZE_H:  misaligned = lsu_addr_o[0];
            default: misaligned = 1'b0;
        endcase
    end

    assign trap        = misaligned && MISALIGN_CHK;
    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req_i) state_d = ADDR_LO;
            ADDR_LO: state_d = ADDR_HI;
            ADDR_HI: state_d = trap ? IDLE : ISSUE;
            ISSUE:   if (lsu_ready_i) state_d = WAIT;
            WAIT: begin
                if (lsu_err_i)        state_d = IDLE;
                else if (lsu_valid_i) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_hi_o     <= 1'b0;
            lsu_start_o <= 1'b0;
            misalign_o  <= 1'b0;
            err_o       <= 1'b0;
            done_o      <= 1'b0;
            lsu_dir_o   <= 1'b0;
            lsu_size_o  <= SIZE_W;
            lsu_ext_o   <= EXT_Z;
            imm_q       <= '0;
            carry_q     <= 1'b0;
            lsu_addr_o  <= '0;
            lsu_wdata_o <= '0;
        end else begin
            // Half select leads the state so the regfile read lines up with ADDR_HI.
            rf_hi_o     <= (state_d == ADDR_HI);
            lsu_start_o <= (state == ISSUE) && lsu_ready_i;
            misalign_o  <= (state == ADDR_HI) && trap;
            err_o       <= (state == WAIT) && lsu_err_i;
            done_o      <= (state == DRAIN);
            if (state == IDLE && req_i) begin
                lsu_dir_o  <= dir_i;
                lsu_size_o <= size_i;
                lsu_ext_o  <= ext_i;
                imm_q      <= imm_i;
            end
            if (state == ADDR_LO) begin
                lsu_addr_o[15:0]  <= sum_lo[15:0];
                carry_q           <= sum_lo[16];
                lsu_wdata_o[15:0] <= rs2_half_i;
            end
            if (state == ADDR_HI) begin
                lsu_addr_o[31:16]  <= sum_hi;
                lsu_wdata_o[31:16] <= rs2_half_i;
            end
        end
    end

endmodule
